// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the iterative HI/LO multiply/divide unit.
//   DATA_W     operand / HI / LO width (only 32 is supported)
//   ACC_W      accumulator width (product, or remainder:quotient)
//   CNT_W      iteration counter width
//   ITER_LAST  last CALC iteration index (32 one-bit steps: 0..31)
//   OP_*       3-bit HI/LO operation encodings from decode
//   state_e    control FSM states
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: combinational single-step datapath of the multiply/divide unit.
//   acc_i       accumulator; multiply: {partial_product, multiplier},
//               divide: {remainder, dividend/quotient}
//   operand_i   multiplicand (multiply) or divisor (divide), unsigned magnitude
//   div_mode_i  0: radix-2 shift-add step, 1: restoring shift-subtract step
//   acc_o       accumulator after one step
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] sub_diff;

  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set, then shift
    // the whole accumulator right; the carry lands in the top bit.
    add_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Divide: remainder shifted left with the next dividend bit; kept 33 bits
    // wide so a remainder with its MSB set is not lost before the trial subtract.
    rem_sh   = acc_i[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_sh - {1'b0, operand_i};

    if (div_mode_i) begin
      if (!sub_diff[WIDTH]) begin
        acc_o = {sub_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        // Restore: rem_sh < divisor here, so its top bit is always 0.
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit in EX; owns the HI/LO registers.
//   clk, clr_n        clock, synchronous active-low reset
//   start, op         HI/LO operation request from ID/EX (op encodings in muldiv_pkg)
//   rs_val, rt_val    forwarded operands
//   flush             aborts the operation in flight, blocks a new start
//   hi, lo            architectural HI/LO
//   busy              combinational stall request to the hazard unit
//   done              one-cycle pulse when HI/LO take a mul/div result
//   div_zero          one-cycle pulse on a divide by zero (HI/LO untouched)
// Build option: define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single CALC
// cycle with the synthesis multiplier; divide always uses 32 restoring steps.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               in_is_muldiv, in_is_div, in_is_signed, accept;
  logic               div_mode;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] iter_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign in_is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign in_is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign in_is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign accept       = start && (op != OP_NONE) && (op != OP_RSVD) && (state_q == IDLE) && !flush;
  assign rs_mag       = (in_is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag       = (in_is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign div_mode     = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Sign correction on the unsigned magnitude result.
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .div_mode_i (div_mode),
    .acc_o      (iter_acc)
  );

  assign busy     = (state_q != IDLE) || (start && in_is_muldiv && !flush);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end else if (in_is_div && (rt_val == '0)) begin
            div_zero_d = 1'b1;
          end else begin
            op_d      = op;
            // Multiply shifts the multiplier out of the low half; divide shifts
            // the dividend out of the low half and the quotient in behind it.
            acc_d     = {{WIDTH{1'b0}}, (in_is_div ? rs_mag : rt_mag)};
            opnd_d    = in_is_div ? rt_mag : rs_mag;
            neg_res_d = in_is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem_d = in_is_signed && rs_val[WIDTH-1];
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          if (!div_mode) begin
            acc_d   = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
            state_d = FIX;
          end else begin
            acc_d = iter_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ITER_LAST) state_d = FIX;
          end
`else
          acc_d = iter_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ITER_LAST) state_d = FIX;
`endif
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (div_mode) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is reset so HI/LO read back as 0
  // after reset and no X can leak from the accumulator into HI/LO.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so all flops update together from
    // values computed before the edge.
    if (!clr_n) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Honours MULDIV_FAST_MUL_EN for the expected multiply busy length.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_vec  = 0;
  int n_miss = 0;
  int nbusy;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 3;
`else
  localparam int MUL_BUSY = 34;
`endif
  localparam int DIV_BUSY = 34;

  muldiv_unit dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle MTHI/MTLO start.
  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    op = o; rs_val = v; rt_val = '0; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
  endtask

  // Issue a mul/div and count busy cycles; returns in the first non-busy cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      tick();
      start = 1'b0; op = 3'd0;
      #1;
    end
    start = 1'b0; op = 3'd0;
  endtask

  initial begin
    clr_n = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; flush = 1'b0;
    tick(); tick();
    clr_n = 1'b1;
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_divz", 32'(div_zero), 32'h0);

    // MULT -3 * 5 = -15
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, nbusy);
    check("mult_busy", 32'(nbusy), 32'(MUL_BUSY));
    check("mult_done", 32'(done), 32'h1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    tick();
    check("mult_done_pulse", 32'(done), 32'h0);

    // DIVU 100 / 7 = 14 r 2
    run_op(3'd4, 32'd100, 32'd7, nbusy);
    check("divu_busy", 32'(nbusy), 32'(DIV_BUSY));
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // DIV -7 / 2 = -3 r -1
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, nbusy);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV 7 / -2 = -3 r 1
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, nbusy);
    check("div_negd_lo", lo, 32'hFFFF_FFFD);
    check("div_negd_hi", hi, 32'd1);

    // Signed overflow 0x80000000 / -1
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nbusy);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);

    // MULTU max * max = 0xFFFFFFFE_00000001
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nbusy);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // MULT 0x80000000 * 0x80000000 = 2^62
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, nbusy);
    check("mult_min_busy", 32'(nbusy), 32'(MUL_BUSY));
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0);

    // MTHI/MTLO preload, then DIV by zero
    mt(3'd5, 32'h11);
    check("mthi", hi, 32'h11);
    check("mthi_busy", 32'(busy), 32'h0);
    mt(3'd6, 32'h22);
    check("mtlo", lo, 32'h22);
    check("mtlo_done", 32'(done), 32'h0);
    run_op(3'd3, 32'd50, 32'd0, nbusy);
    check("dz_busy", 32'(nbusy), 32'd1);
    check("dz_pulse", 32'(div_zero), 32'h1);
    check("dz_done", 32'(done), 32'h0);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    tick();
    check("dz_pulse_end", 32'(div_zero), 32'h0);
    check("dz_done_after", 32'(done), 32'h0);

    // DIVU with flush mid-CALC; a MTLO during busy is ignored. Divide keeps the
    // timing identical in both builds.
    op = 3'd4; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    repeat (3) tick();
    op = 3'd6; rs_val = 32'hDEAD; start = 1'b1;
    #1;
    check("ign_busy", 32'(busy), 32'h1);
    tick();
    start = 1'b0; op = 3'd0;
    check("ign_lo", lo, 32'h22);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_done", 32'(done), 32'h0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);
    tick();
    check("flush_done_later", 32'(done), 32'h0);

    // Start with flush=1 is ignored
    op = 3'd1; rs_val = 32'd3; rt_val = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    check("startflush_busy", 32'(busy), 32'h0);
    tick();
    start = 1'b0; op = 3'd0; flush = 1'b0;
    #1;
    check("startflush_idle", 32'(busy), 32'h0);

    // Reset at cycle 20 of a DIV
    op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    repeat (19) tick();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    run_op(3'd4, 32'd9, 32'd3, nbusy);
    check("post_rst_busy", 32'(nbusy), 32'(DIV_BUSY));
    check("post_rst_lo", lo, 32'd3);
    check("post_rst_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded HI/LO operation and the rs/rt operand values latched by ID/EX.
- Runs MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers.
- Drives a busy stall request to the hazard unit, which freezes PC, IF/ID and ID/EX while the unit is busy.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is supported; all cycle counts below assume 32.

Ports:
- clk  in  1  clock, all state updates on posedge
- clr_n  in  1  synchronous active-low reset
- start  in  1  valid instruction in EX with a HI/LO op (ID/EX Enable_out qualified)
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs_val  in  WIDTH  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  WIDTH  forwarded rt operand (divisor / multiplier)
- flush  in  1  EX flush (branch/exception); aborts the operation in flight
- hi  out  WIDTH  HI register (read by MFHI)
- lo  out  WIDTH  LO register (read by MFLO)
- busy  out  1  stall request, combinational
- done  out  1  one-cycle pulse when HI/LO take a mul/div result
- div_zero  out  1  one-cycle pulse on a divide by zero

Behaviour:
- Reset (clr_n=0 at an edge): state IDLE; hi, lo, counter and internal registers 0; done=0; div_zero=0. Reset wins over every other input, including mid-operation.
- Accept condition: start=1, op!=NONE, state IDLE and flush=0, sampled at edge E0. start while busy, or with flush=1, is ignored.
- MTHI/MTLO: at E0, hi (or lo) <= rs_val. No busy beyond the start cycle; done stays 0.
- MUL/DIV accept at E0:
  - Latch op.
  - Signed ops (MULT, DIV): store operand magnitudes plus the result sign bits.
  - Unsigned ops: store operands as-is.
  - Clear the 6-bit counter and enter CALC.
- CALC, 32 cycles, E1..E32, one bit per cycle:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract giving 32-bit quotient and remainder.
  - Leave CALC when the counter reaches 31.
- FIX, 1 cycle (edge E33):
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo: MUL gives hi=product[63:32], lo=product[31:0]; DIV gives lo=quotient, hi=remainder.
  - Return to IDLE.
- done=1 in the cycle after E33; this is the first cycle in which the new hi/lo are visible.
- busy = (state!=IDLE) | (start & op in MULT..DIVU & flush=0). It is high from the start cycle through the FIX cycle (34 cycles) and low in the cycle where done=1.
- Divide by zero (rt_val==0 on DIV/DIVU): detected at E0, no CALC. hi/lo unchanged, div_zero=1 in the cycle after E0, busy high only in the start cycle, done=0.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude arithmetic and needs no special case.
- flush=1 in CALC or FIX: at that edge go to IDLE, hi/lo unchanged, done=0.
- Same-edge clr_n=0 and flush: reset applies.
- Counter wraps never occur: it only counts 0..31 inside CALC.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: MULT/MULTU compute the full 64-bit product in a single CALC cycle using the synthesis multiplier (DSP), then FIX. busy spans 3 cycles and done follows at E2+1. Divide is unchanged.
  - Undefined: multiply uses the 32-cycle shift-add path described above.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_NONE..OP_MTLO
  - state enum IDLE/CALC/FIX
  - ITER_LAST=31 and WIDTH-derived constants
- Sub-module muldiv_iter: combinational single-step datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator, for either a shift-add or a shift-subtract step.
  - The top level holds the FSM, counter, sign fix and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high 34 cycles; then done=1 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU rs=100, rt=7 -> lo=14, hi=2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rt=0 with hi/lo preloaded to 0x11/0x22 via MTHI/MTLO -> div_zero pulses, done never pulses, hi/lo stay 0x11/0x22, busy 1 cycle.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with flush at cycle 10 of CALC -> busy drops the next cycle, hi/lo unchanged; a MTLO start during busy is ignored.
- clr_n=0 at cycle 20 of a DIV -> next cycle: busy=0, hi=lo=0, done=0; a subsequent DIVU 9/3 gives lo=3, hi=0.
- With MULDIV_FAST_MUL_EN: MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0, busy exactly 3 cycles.
